// File: rtl/mch_tx_sched_if.sv
// Requester/transmitter-side signal bundle for the Manchester TX frame scheduler.
interface mch_tx_sched_if;
  logic        en;
  logic        req0, req1;
  logic [31:0] data0, data1;
  logic        ack0, ack1;
  logic        done0, done1;
  logic        start;
  logic [7:0]  pd0, pd1, pd2, pd3;
  logic        busy;
  logic        gnt_id;

  modport slave (
    input  en, req0, data0, req1, data1,
    output ack0, ack1, done0, done1, start, pd0, pd1, pd2, pd3, busy, gnt_id
  );

  modport master (
    output en, req0, data0, req1, data1,
    input  ack0, ack1, done0, done1, start, pd0, pd1, pd2, pd3, busy, gnt_id
  );
endinterface

// File: rtl/mch_tx_sched.sv
// Round-robin scheduler sharing one Manchester transmitter between two requesters.
// Latches the winner's payload, pulses start, then holds off for frame + guard gap.
module mch_tx_sched #(
  parameter int FRAME_CYCLES = 7000,
  parameter int GAP_CYCLES   = 200,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  mch_tx_sched_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, START, XMIT, GAP} state_t;

  localparam logic [CNT_W-1:0] FRAME_LD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [31:0]      pd_q, pd_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             win;

  // On a tie the requester not served last wins; a lone requester always wins.
  assign win = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    pd_d    = pd_q;
    ack_d   = 2'b00;
    done_d  = 2'b00;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && (bus.req0 || bus.req1)) begin
          state_d = LOAD;
          gnt_d   = win;
          last_d  = win;
          pd_d    = win ? bus.data1 : bus.data0;
          ack_d   = win ? 2'b10 : 2'b01;
        end
      end
      LOAD: begin
        state_d = START;
        start_d = 1'b1;
      end
      START: begin
        state_d = XMIT;
        cnt_d   = FRAME_LD;
      end
      XMIT: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end else begin
            state_d = IDLE;
            done_d  = gnt_q ? 2'b10 : 2'b01;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = gnt_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      pd_q    <= '0;
      ack_q   <= 2'b00;
      done_q  <= 2'b00;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      pd_q    <= pd_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.ack0   = ack_q[0];
  assign bus.ack1   = ack_q[1];
  assign bus.done0  = done_q[0];
  assign bus.done1  = done_q[1];
  assign bus.start  = start_q;
  assign bus.busy   = busy_q;
  assign bus.gnt_id = gnt_q;
  assign bus.pd0    = pd_q[7:0];
  assign bus.pd1    = pd_q[15:8];
  assign bus.pd2    = pd_q[23:16];
  assign bus.pd3    = pd_q[31:24];

endmodule

// File: tb/tb_mch_tx_sched.sv
// Directed bench for mch_tx_sched: a scoreboard of expected ack/start/done pulses
// (with cycle, grant id and payload) plus point checks on busy/pd/reset values.
module tb_mch_tx_sched;
  localparam int F  = 20;
  localparam int G  = 4;
  localparam int FB = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mch_tx_sched_if ifa();
  mch_tx_sched_if ifb();

  mch_tx_sched #(.FRAME_CYCLES(F), .GAP_CYCLES(G), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  mch_tx_sched #(.FRAME_CYCLES(FB), .GAP_CYCLES(0), .CNT_W(8)) dut_g0 (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 ack0, 2 ack1, 3 start, 4 done0, 5 done1
  typedef struct packed {
    logic [2:0]  kind;
    logic        gid;
    logic [31:0] pd;
    logic [31:0] cyc;
  } ev_t;

  ev_t sbq[$];
  ev_t mon_o, mon_e;
  logic [4:0] pv;

  function automatic ev_t mk(input int kind, input logic gid, input logic [31:0] pd, input int c);
    ev_t e;
    e.kind = 3'(kind);
    e.gid  = gid;
    e.pd   = pd;
    e.cyc  = 32'(c);
    return e;
  endfunction

  function automatic logic [31:0] val(input int k);
    return {8'hA5, 8'(k), 8'h5A, 8'(255 - k)};
  endfunction

  // A grant decided in IDLE cycle t: ack t+1, start t+2, done t+3+F+G.
  task automatic push_frame(input logic id, input int t, input logic [31:0] d, input bit with_done);
    sbq.push_back(mk(id ? 2 : 1, id, d, t + 1));
    sbq.push_back(mk(3, id, d, t + 2));
    if (with_done) sbq.push_back(mk(id ? 5 : 4, id, d, t + 3 + F + G));
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    pv = {ifa.done1, ifa.done0, ifa.start, ifa.ack1, ifa.ack0};
    for (int i = 0; i < 5; i++) begin
      if (pv[i]) begin
        mon_o = mk(i + 1, ifa.gnt_id, {ifa.pd3, ifa.pd2, ifa.pd1, ifa.pd0}, cyc);
        mon_e = (sbq.size() > 0) ? sbq.pop_front() : mk(0, 1'b0, 32'h0, -1);
        checks++;
        assert (mon_o === mon_e) else begin
          errors++;
          $error("FAIL sb_event observed kind=%0d gid=%0d pd=%h cyc=%0d expected kind=%0d gid=%0d pd=%h cyc=%0d",
                 mon_o.kind, mon_o.gid, mon_o.pd, mon_o.cyc, mon_e.kind, mon_e.gid, mon_e.pd, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, e, r;
    ifa.en = 1'b1; ifa.req0 = 1'b0; ifa.req1 = 1'b0; ifa.data0 = '0; ifa.data1 = '0;
    ifb.en = 1'b1; ifb.req0 = 1'b0; ifb.req1 = 1'b0; ifb.data0 = '0; ifb.data1 = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busy", 64'(ifa.busy), 64'd0);
    chk("rst_pd", 64'({ifa.pd3, ifa.pd2, ifa.pd1, ifa.pd0}), 64'd0);
    chk("rst_gnt_id", 64'(ifa.gnt_id), 64'd0);
    chk("rst_pulses", 64'({ifa.ack0, ifa.ack1, ifa.done0, ifa.done1, ifa.start}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // GAP_CYCLES=0 instance: done exactly FB+1 cycles after start
    t = cyc;
    ifb.req0 = 1'b1; ifb.data0 = 32'hDEADBEEF;
    at(t + 1);
    chk("g0_ack", 64'({ifb.ack1, ifb.ack0}), 64'b01);
    chk("g0_pd", 64'({ifb.pd3, ifb.pd2, ifb.pd1, ifb.pd0}), 64'hDEADBEEF);
    ifb.req0 = 1'b0;
    at(t + 2);
    chk("g0_start", 64'(ifb.start), 64'd1);
    at(t + 2 + FB);
    chk("g0_last_xmit", 64'({ifb.busy, ifb.done0}), 64'b10);
    at(t + 3 + FB);
    chk("g0_done", 64'({ifb.busy, ifb.done0}), 64'b01);
    at(t + 4 + FB);
    chk("g0_idle", 64'({ifb.busy, ifb.done0, ifb.start}), 64'd0);

    // Single request: ack/start/done timing, byte mapping, busy window
    t = cyc;
    ifa.req0 = 1'b1; ifa.data0 = 32'h44434241;
    push_frame(1'b0, t, 32'h44434241, 1'b1);
    at(t + 1);
    ifa.req0 = 1'b0;
    chk("t1_bytes", 64'({ifa.pd0, ifa.pd1, ifa.pd2, ifa.pd3}), 64'h41424344);
    chk("t1_busy_first", 64'(ifa.busy), 64'd1);
    at(t + 26);
    chk("t1_busy_last", 64'(ifa.busy), 64'd1);
    at(t + 27);
    chk("t1_busy_done", 64'(ifa.busy), 64'd0);
    at(t + 28);

    // Request raised mid-frame, data changed while pending
    t = cyc;
    ifa.req0 = 1'b1; ifa.data0 = 32'h0A0B0C0D;
    push_frame(1'b0, t, 32'h0A0B0C0D, 1'b1);
    push_frame(1'b1, t + 3 + F + G, 32'h5555AAAA, 1'b1);
    at(t + 1);
    ifa.req0 = 1'b0;
    at(t + 10);
    ifa.req1 = 1'b1; ifa.data1 = 32'h11111111;
    at(t + 15);
    ifa.data1 = 32'h5555AAAA;
    chk("t3_pd_hold", 64'({ifa.pd3, ifa.pd2, ifa.pd1, ifa.pd0}), 64'h0A0B0C0D);
    at(t + 28);
    ifa.req1 = 1'b0; ifa.data1 = 32'hFFFFFFFF;
    at(t + 56);

    // en=0 blocks the grant; dropping en mid-frame does not disturb it
    t = cyc;
    ifa.en = 1'b0; ifa.req0 = 1'b1; ifa.data0 = 32'h12345678;
    at(t + 5);
    chk("t5_blocked_busy", 64'(ifa.busy), 64'd0);
    e = t + 5;
    ifa.en = 1'b1;
    push_frame(1'b0, e, 32'h12345678, 1'b1);
    at(e + 1);
    ifa.req0 = 1'b0;
    at(e + 10);
    ifa.en = 1'b0;
    at(e + 27);
    chk("t5_done_idle", 64'(ifa.busy), 64'd0);
    ifa.req1 = 1'b1; ifa.data1 = 32'hCAFEF00D;
    at(e + 32);
    chk("t5_en0_no_grant", 64'(ifa.busy), 64'd0);

    // Reset mid-XMIT, then a fresh full-length grant with no stale done
    t = cyc;
    ifa.en = 1'b1;
    push_frame(1'b1, t, 32'hCAFEF00D, 1'b0);
    at(t + 5);
    chk("t6_gnt_before", 64'(ifa.gnt_id), 64'd1);
    at(t + 10);
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(ifa.busy), 64'd0);
    chk("t6_rst_pulses", 64'({ifa.ack0, ifa.ack1, ifa.done0, ifa.done1, ifa.start}), 64'd0);
    chk("t6_rst_pd", 64'({ifa.pd3, ifa.pd2, ifa.pd1, ifa.pd0}), 64'd0);
    chk("t6_rst_gnt", 64'(ifa.gnt_id), 64'd0);
    at(t + 12);
    rst = 1'b1;
    r = t + 12;
    ifa.data1 = 32'h600DF00D;
    push_frame(1'b1, r, 32'h600DF00D, 1'b1);
    at(r + 1);
    ifa.req1 = 1'b0;
    at(r + 30);

    // Both requesting from reset: alternate 0,1,0,1 with starts 27 cycles apart
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    t = cyc;
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    ifa.data0 = val(0); ifa.data1 = val(1);
    for (int k = 0; k < 4; k++) push_frame(1'(k % 2), t + k * (3 + F + G), val(k), 1'b1);
    for (int k = 0; k < 4; k++) begin
      at(t + k * (3 + F + G) + 1);
      chk("t2_gnt_id", 64'(ifa.gnt_id), 64'(k % 2));
      if (k + 2 < 4) begin
        if (k % 2 == 0) ifa.data0 = val(k + 2);
        else            ifa.data1 = val(k + 2);
      end
    end
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    at(t + 4 * (3 + F + G) + 4);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
